// File: rtl/peripheral_crc_7_check_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_crc_7_check_if
// Description : J1 I/O bus bundle for the CRC-7 checker peripheral.
// Revision    : 1.0
// ============================================================================
interface peripheral_crc_7_check_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    modport master (
        output d_in,
        output cs,
        output addr,
        output rd,
        output wr,
        input  d_out
    );

    modport slave (
        input  d_in,
        input  cs,
        input  addr,
        input  rd,
        input  wr,
        output d_out
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_crc_7_check.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_crc_7_check
// Description : Bit-serial CRC-7 (x^7+x^3+1) checker of a 32-bit word on J1 I/O.
// Revision    : 1.0
// ============================================================================
module peripheral_crc_7_check (
    input  wire logic                     clk,
    input  wire logic                     rst,
    peripheral_crc_7_check_if.slave       bus
);

    localparam logic [3:0] ADDR_DATA_HI = 4'h0;
    localparam logic [3:0] ADDR_DATA_LO = 4'h2;
    localparam logic [3:0] ADDR_CRC_RX  = 4'h4;
    localparam logic [3:0] ADDR_START   = 4'h6;
    localparam logic [3:0] ADDR_STATUS  = 4'h8;
    localparam logic [3:0] ADDR_CRC     = 4'hA;

    localparam logic [6:0] POLY         = 7'h09;
    localparam logic [4:0] LAST_BIT     = 5'd31;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SHIFT     = 2'd1;
    localparam logic [1:0] ST_CMP       = 2'd2;

    // Bus-side registers (negedge domain)
    logic [31:0] data;
    logic [6:0]  crc_rx;
    logic        start;
    logic [15:0] d_out_q;
    logic [15:0] rd_data;
    logic        wr_en;
    logic        rd_en;

    // Engine registers (posedge domain)
    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [31:0] sh;
    logic [4:0]  cnt;
    logic [6:0]  crc_calc;
    logic        done;
    logic        match;
    logic        busy;

    logic        load;
    logic        shift_en;
    logic        cmp_en;
    logic        fb;

    assign wr_en = bus.cs & bus.wr;
    assign rd_en = bus.cs & bus.rd;

    always_comb begin
        rd_data = 16'h0000;
        if (rd_en) begin
            case (bus.addr)
                ADDR_STATUS: rd_data = {13'b0, busy, match, done};
                ADDR_CRC:    rd_data = {9'b0, crc_calc};
                default:     rd_data = 16'h0000;
            endcase
        end
    end

    // start is re-evaluated every negedge, so one write cycle yields one period.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            data    <= 32'h0000_0000;
            crc_rx  <= 7'h00;
            start   <= 1'b0;
            d_out_q <= 16'h0000;
        end else begin
            start   <= wr_en && (bus.addr == ADDR_START);
            d_out_q <= rd_data;
            if (wr_en) begin
                case (bus.addr)
                    ADDR_DATA_HI: data[31:16] <= bus.d_in;
                    ADDR_DATA_LO: data[15:0]  <= bus.d_in;
                    ADDR_CRC_RX:  crc_rx      <= bus.d_in[6:0];
                    default:      ;
                endcase
            end
        end
    end

    assign bus.d_out = d_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) next_state = ST_CMP;
            ST_CMP:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // A start seen outside IDLE never reaches load, so a running check is untouched.
    always_comb begin
        load     = (state == ST_IDLE) && start;
        shift_en = (state == ST_SHIFT);
        cmp_en   = (state == ST_CMP);
    end

    assign fb = sh[31] ^ crc_calc[6];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh       <= 32'h0000_0000;
            cnt      <= 5'd0;
            crc_calc <= 7'h00;
            done     <= 1'b0;
            match    <= 1'b0;
            busy     <= 1'b0;
        end else if (load) begin
            sh       <= data;
            cnt      <= 5'd0;
            crc_calc <= 7'h00;
            done     <= 1'b0;
            match    <= 1'b0;
            busy     <= 1'b1;
        end else if (shift_en) begin
            crc_calc <= {crc_calc[5:0], 1'b0} ^ (fb ? POLY : 7'h00);
            sh       <= {sh[30:0], 1'b0};
            cnt      <= cnt + 5'd1;
        end else if (cmp_en) begin
            match    <= (crc_calc == crc_rx);
            done     <= 1'b1;
            busy     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_crc_7_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_crc_7_check
// Description : Directed, table-driven bench for the CRC-7 checker peripheral.
// Revision    : 1.0
// ============================================================================
module tb_peripheral_crc_7_check;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    peripheral_crc_7_check_if bus_if ();

    peripheral_crc_7_check dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [31:0] data;
        logic [6:0]  crc_rx;
        logic [15:0] status;
        logic [15:0] crc;
    } vec_t;

    vec_t vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC-7, MSB first, zero initial value
    function automatic logic [6:0] crc7_ref(input logic [31:0] d);
        logic [6:0] c;
        logic       f;
        c = 7'h00;
        for (int i = 31; i >= 0; i--) begin
            f = d[i] ^ c[6];
            c = {c[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.cs   = 1'b0;
        bus_if.rd   = 1'b0;
        bus_if.wr   = 1'b0;
        bus_if.addr = 4'h0;
        bus_if.d_in = 16'h0000;
    endtask

    // One bus cycle; d_out latched at the negedge is returned at the following posedge.
    task automatic bus_cycle(input logic c, input logic r, input logic w,
                             input logic [3:0] a, input logic [15:0] d,
                             output logic [15:0] v);
        @(posedge clk);
        #1;
        bus_if.cs   = c;
        bus_if.rd   = r;
        bus_if.wr   = w;
        bus_if.addr = a;
        bus_if.d_in = d;
        @(negedge clk);
        #1;
        bus_idle();
        @(posedge clk);
        v = bus_if.d_out;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        bus_cycle(1'b1, 1'b0, 1'b1, a, d, dummy);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] v);
        bus_cycle(1'b1, 1'b1, 1'b0, a, 16'h0000, v);
    endtask

    task automatic load_and_start(input logic [31:0] d, input logic [6:0] c);
        bus_wr(4'h0, d[31:16]);
        bus_wr(4'h2, d[15:0]);
        bus_wr(4'h4, {9'b0, c});
        bus_wr(4'h6, 16'h0000);
    endtask

    logic [15:0] v;
    logic        was_read;
    int          done_first;
    int          busy_bad;
    int          post_bad;
    logic [6:0]  crc_ff;

    initial begin
        tests = 0;
        fails = 0;
        bus_idle();
        rst = 1'b0;

        // data=0x100 -> 0x0B and data=0x181 -> 0x0B^0x41^0x09 = 0x43 by linearity
        vecs[0] = '{32'h0000_0000, 7'h00, 16'h0003, 16'h0000};
        vecs[1] = '{32'h0000_0001, 7'h09, 16'h0003, 16'h0009};
        vecs[2] = '{32'h0000_0080, 7'h41, 16'h0003, 16'h0041};
        vecs[3] = '{32'h0000_0080, 7'h40, 16'h0001, 16'h0041};
        vecs[4] = '{32'h0000_0100, 7'h0B, 16'h0003, 16'h000B};
        vecs[5] = '{32'h0000_0181, 7'h7F, 16'h0001, 16'h0043};

        #13;
        check("reset_dout", bus_if.d_out, 16'h0000);
        #10;
        rst = 1'b1;
        bus_rd(4'h8, v);
        check("reset_status", v, 16'h0000);
        bus_rd(4'hA, v);
        check("reset_crc", v, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            load_and_start(vecs[i].data, vecs[i].crc_rx);
            repeat (36) @(negedge clk);
            bus_rd(4'h8, v);
            check($sformatf("vec%0d_status", i), v, vecs[i].status);
            bus_rd(4'hA, v);
            check($sformatf("vec%0d_crc", i), v, vecs[i].crc);
        end

        // Exact latency and busy protection; status polled every cycle.
        load_and_start(32'h0000_0080, 7'h41);
        bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.wr = 1'b0; bus_if.addr = 4'h8;
        was_read   = 1'b1;
        done_first = -1;
        busy_bad   = 0;
        post_bad   = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            #1;
            if (was_read) begin
                if (done_first < 0 && bus_if.d_out[0]) done_first = k;
                if (k <= 32 && bus_if.d_out != 16'h0004) busy_bad++;
                if (k >= 33 && bus_if.d_out != 16'h0003) post_bad++;
            end
            bus_if.cs = 1'b1;
            case (k)
                9:  begin bus_if.rd = 1'b0; bus_if.wr = 1'b1; bus_if.addr = 4'h0; bus_if.d_in = 16'hFFFF; end
                10: begin bus_if.rd = 1'b0; bus_if.wr = 1'b1; bus_if.addr = 4'h2; bus_if.d_in = 16'hFFFF; end
                11: begin bus_if.rd = 1'b0; bus_if.wr = 1'b1; bus_if.addr = 4'h6; bus_if.d_in = 16'h0000; end
                default: begin bus_if.rd = 1'b1; bus_if.wr = 1'b0; bus_if.addr = 4'h8; end
            endcase
            was_read = bus_if.rd;
        end
        bus_idle();
        check("lat_done_cycle", 16'(done_first), 16'd33);
        check("lat_busy_window_errs", 16'(busy_bad), 16'd0);
        check("lat_post_done_errs", 16'(post_bad), 16'd0);
        bus_rd(4'hA, v);
        check("protect_orig_crc", v, 16'h0041);

        crc_ff = crc7_ref(32'hFFFF_FFFF);
        bus_wr(4'h4, {9'b0, crc_ff});
        bus_wr(4'h6, 16'h0000);
        repeat (36) @(negedge clk);
        bus_rd(4'hA, v);
        check("later_ffff_crc", v, {9'b0, crc_ff});
        bus_rd(4'h8, v);
        check("later_ffff_status", v, 16'h0003);

        // Bus decode: stray write to 0xC, write with cs=0
        load_and_start(32'h0000_0001, 7'h09);
        repeat (36) @(negedge clk);
        bus_wr(4'hC, 16'hFFFF);
        bus_cycle(1'b0, 1'b0, 1'b1, 4'h2, 16'hFFFF, v);
        bus_wr(4'h6, 16'h0000);
        repeat (36) @(negedge clk);
        bus_rd(4'hA, v);
        check("dec_wr_0xC_crc", v, 16'h0009);
        bus_rd(4'h8, v);
        check("dec_wr_0xC_status", v, 16'h0003);
        bus_cycle(1'b0, 1'b1, 1'b0, 4'h8, 16'h0000, v);
        check("dec_rd_cs0", v, 16'h0000);
        bus_rd(4'h0, v);
        check("dec_rd_addr0", v, 16'h0000);
        bus_wr(4'h2, 16'h0080);
        bus_cycle(1'b1, 1'b1, 1'b0, 4'h6, 16'h0000, v);
        repeat (36) @(negedge clk);
        bus_rd(4'hA, v);
        check("dec_rd_start_crc", v, 16'h0009);
        bus_rd(4'h8, v);
        check("dec_rd_start_status", v, 16'h0003);

        // Reset mid-SHIFT after a completed check
        load_and_start(32'h0000_0080, 7'h41);
        repeat (36) @(negedge clk);
        bus_wr(4'h6, 16'h0000);
        bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = 4'h8;
        repeat (10) @(negedge clk);
        #1;
        check("mid_shift_busy", bus_if.d_out, 16'h0004);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_dout", bus_if.d_out, 16'h0000);
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold_dout", bus_if.d_out, 16'h0000);
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus_idle();
        bus_rd(4'h8, v);
        check("post_rst_status", v, 16'h0000);
        bus_rd(4'hA, v);
        check("post_rst_crc", v, 16'h0000);
        bus_wr(4'h6, 16'h0000);
        repeat (36) @(negedge clk);
        bus_rd(4'h8, v);
        check("post_rst_cleared_regs_status", v, 16'h0003);
        bus_rd(4'hA, v);
        check("post_rst_cleared_regs_crc", v, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
